mmio_uart_tx: RTL
=================

Name: mmio_uart_tx

Overview:
Memory-mapped UART transmitter that sits on the processor core's data-bus side as a bus responder, alongside data memory. The core issues loads and stores through the d_* bus. This block decodes its own address window, buffers written bytes in a small FIFO, and serialises them as 8N1 frames on a tx pin. Read data is returned combinationally, because the core bus has no wait-state signal. The SoC top uses the hit output to select between this block's read data and data memory's.

Parameters:
BASE_ADDR, 32'hFFFF_0000, base of the 16-byte register window; bits [3:0] are ignored.
FIFO_DEPTH, 4, TX FIFO entries; must be a power of 2, 2..16.
DEFAULT_DIV, 16, clocks per serial bit after reset.

Ports:
clk  in  1  system clock; all state updates on rising edge.
reset  in  1  synchronous, active-low reset, sampled on rising edge of clk.
d_addr  in  32  bus byte address from core.
d_wdata  in  32  bus store data.
d_we  in  1  store strobe; acted on at the clock edge.
d_re  in  1  load strobe.
d_rdata  out  32  load data, combinational.
hit  out  1  combinational; 1 when d_addr[31:4]==BASE_ADDR[31:4] and (d_we|d_re).
tx  out  1  serial output, idle high.
busy  out  1  1 when FIFO is non-empty or the FSM is not IDLE.

Behaviour:
- Register map: offset = d_addr[3:2]; d_addr[1:0] are ignored.
- 0x0 TXDATA. W: push d_wdata[7:0] into the FIFO. R: returns 0.
- 0x4 STATUS. R: [0]=busy, [1]=fifo_full, [2]=fifo_empty, [3]=overflow (sticky), [12:8]=fifo_count, other bits 0. W: writing 1 to bit 3 clears overflow; other bits are ignored.
- 0x8 DIV. R/W, 16 bits in [15:0]; upper bits read 0. A write of 0 stores 1.
- 0xC TXCOUNT. R: 32-bit count of completed frames, wraps at 2^32. W: any write clears it to 0.
- d_rdata = selected register when hit & d_re; otherwise 32'h0. Reads have no side effects.
- Writes take effect only when hit & d_we at the rising edge. If d_we and d_re are both high, the write proceeds and d_rdata shows the pre-edge value.
- Push to a full FIFO: the byte is dropped and overflow is set, unless a pop occurs in the same cycle. In that case the push is accepted and fifo_count is unchanged.
- Reset (reset==0 at an edge): tx=1, busy=0, FIFO empty, fifo_count=0, DIV=DEFAULT_DIV, TXCOUNT=0, overflow=0, FSM=IDLE, bit and baud counters=0.
- Reset mid-frame aborts the frame and discards FIFO contents; tx is high after that edge.
- FSM states and transitions:
  - IDLE: tx=1. If the FIFO is non-empty at an edge: pop the head into the shift register, latch DIV into the active divisor, go to START.
  - START: tx=0 for div clocks, then go to DATA.
  - DATA: 8 bits LSB first, each held div clocks; a 3-bit counter tracks bit index.
  - STOP: tx=1 for div clocks. On completion, TXCOUNT increments. If the FIFO is non-empty, pop directly into START (back-to-back frames, no idle gap); otherwise go to IDLE.
- Baud counter counts 0..div-1 and advances the bit at div-1.
- A DIV write during a frame takes effect only at the next frame's start.
- Latency: a TXDATA write sampled at edge k with the FSM IDLE and FIFO empty makes tx go low after edge k+1. The frame lasts exactly 10*div clocks. busy goes high after edge k and low after the final stop-bit edge.
- TXCOUNT write coincident with frame completion: the clear wins.
- FIFO uses read/write pointers of log2(FIFO_DEPTH)+1 bits; full/empty are derived from pointer MSB compare.

Test Plan:
- Reset with reset=0 for 2 clocks, then release -> tx=1, busy=0, STATUS read=32'h0000_0004, DIV read=16.
- Write DIV=4, then TXDATA=0xA5 -> tx low after 1 edge; sequence 0,1,0,1,0,0,1,0,1,1, each level held 4 clocks; TXCOUNT=1; busy drops after 40 clocks.
- DIV=2, write 0x01,0x02,0x03,0x04,0x05 back-to-back with no frames drained -> first byte is popped so 5 are accepted; 6th write sets overflow (STATUS[3]=1); 5 frames emitted contiguously (no idle gap); writing 1 to STATUS bit 3 clears overflow.
- Assert reset at clock 7 of a frame with DIV=4 -> tx=1 next edge, FIFO empty, TXCOUNT=0, no further frames.
- Read d_addr=BASE+0x10 with d_re=1 -> hit=0, d_rdata=0. Read BASE+0xB -> hit=1, returns DIV (byte bits ignored).
- Write DIV=0 -> DIV reads 1; frame 0x00 lasts 10 clocks. Write DIV=8 mid-frame -> current frame keeps the old timing, next frame uses 8.

Source files
------------

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter with a small TX FIFO.
// Registers: TXDATA, STATUS, DIV, TXCOUNT in a 16-byte window.
module mmio_uart_tx #(
    parameter logic [31:0] BASE_ADDR   = 32'hFFFF_0000,
    parameter int unsigned FIFO_DEPTH  = 4,
    parameter logic [15:0] DEFAULT_DIV = 16'd16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic        d_we,
    input  logic        d_re,
    output logic [31:0] d_rdata,
    output logic        hit,
    output logic        tx,
    output logic        busy
);
    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

    state_e      state_q, state_d;
    logic [AW:0] wptr_q, wptr_d;
    logic [AW:0] rptr_q, rptr_d;
    logic [7:0]  mem_q [FIFO_DEPTH];
    logic [7:0]  mem_d [FIFO_DEPTH];
    logic [7:0]  shift_q, shift_d;
    logic [15:0] div_q, div_d;
    logic [15:0] adiv_q, adiv_d;
    logic [15:0] baud_q, baud_d;
    logic [2:0]  bit_q, bit_d;
    logic [31:0] txcnt_q, txcnt_d;
    logic        ovf_q, ovf_d;
    logic        tx_q, tx_d;

    logic          wr, push_req, push, pop, done, tick;
    logic          full, empty;
    logic [1:0]    off;
    logic [AW:0]   count;
    logic [4:0]    cnt5;
    logic [AW-1:0] widx, ridx;
    logic          unused_bits;

    assign hit = (d_addr[31:4] == BASE_ADDR[31:4]) && (d_we || d_re);
    assign off = d_addr[3:2];
    assign wr = hit && d_we;
    assign push_req = wr && (off == 2'd0);

    assign widx = wptr_q[AW-1:0];
    assign ridx = rptr_q[AW-1:0];
    assign count = wptr_q - rptr_q;
    assign cnt5 = 5'(count);
    assign empty = (wptr_q == rptr_q);
    assign full = (wptr_q[AW] != rptr_q[AW]) && (widx == ridx);

    // A push into a full FIFO still lands if the same edge pops the head.
    assign push = push_req && (!full || pop);
    assign tick = (baud_q == adiv_q - 16'd1);
    assign busy = !empty || (state_q != IDLE);
    assign tx = tx_q;
    assign unused_bits = ^{d_addr[1:0], d_wdata[31:16]};

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        adiv_d  = adiv_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        pop     = 1'b0;
        done    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!empty) pop = 1'b1;
            end
            START: begin
                baud_d = baud_q + 16'd1;
                if (tick) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = DATA;
                end
            end
            DATA: begin
                baud_d = baud_q + 16'd1;
                if (tick) begin
                    baud_d  = '0;
                    shift_d = {1'b0, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) state_d = STOP;
                end
            end
            STOP: begin
                baud_d = baud_q + 16'd1;
                if (tick) begin
                    baud_d  = '0;
                    done    = 1'b1;
                    state_d = IDLE;
                    if (!empty) pop = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        if (pop) begin
            shift_d = mem_q[ridx];
            adiv_d  = div_q;
            baud_d  = '0;
            bit_d   = '0;
            state_d = START;
        end
    end

    always_comb begin
        tx_d = 1'b1;
        unique case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
            default: tx_d = 1'b1;
        endcase
    end

    always_comb begin
        mem_d = mem_q;
        if (push) mem_d[widx] = d_wdata[7:0];
        wptr_d  = wptr_q + {{AW{1'b0}}, push};
        rptr_d  = rptr_q + {{AW{1'b0}}, pop};
        div_d   = div_q;
        ovf_d   = ovf_q;
        txcnt_d = txcnt_q + {31'd0, done};
        if (push_req && full && !pop) ovf_d = 1'b1;
        if (wr) begin
            case (off)
                2'd1: if (d_wdata[3]) ovf_d = 1'b0;
                2'd2: div_d = (d_wdata[15:0] == 16'd0) ? 16'd1 : d_wdata[15:0];
                2'd3: txcnt_d = '0;
                default: ;
            endcase
        end
    end

    always_comb begin
        d_rdata = '0;
        if (hit && d_re) begin
            case (off)
                2'd1: d_rdata = {19'd0, cnt5, 4'd0, ovf_q, empty, full, busy};
                2'd2: d_rdata = {16'd0, div_q};
                2'd3: d_rdata = txcnt_q;
                default: d_rdata = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            wptr_q  <= '0;
            rptr_q  <= '0;
            shift_q <= '0;
            div_q   <= DEFAULT_DIV;
            adiv_q  <= DEFAULT_DIV;
            baud_q  <= '0;
            bit_q   <= '0;
            txcnt_q <= '0;
            ovf_q   <= 1'b0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            shift_q <= shift_d;
            div_q   <= div_d;
            adiv_q  <= adiv_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            txcnt_q <= txcnt_d;
            ovf_q   <= ovf_d;
            tx_q    <= tx_d;
        end
    end
endmodule
